// File: rtl/avl_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// avl_burst_mem_slave
//
// Avalon-MM burst slave backed by a single-port 32-bit word RAM. It serves
// single and burst reads/writes from the cache/IO master and returns read
// data through a fixed-latency pipeline.
//
// Ports
//   clk                   clock, all logic on the rising edge
//   rest                  synchronous reset, active-high
//   s_address[31:0]       byte address; word index = s_address[ADDR_WIDTH+1:2]
//   s_byteEnable[3:0]     write byte lanes (ignored for reads)
//   s_read                read request
//   s_write               write request / write beat
//   s_writeData[31:0]     write data
//   s_waitRequest         1 = command not accepted this cycle
//   s_beginBurstTransfer  informational only, not used for decode
//   s_burstCount          beats in the burst; 0 is treated as 1
//   s_readData[31:0]      read data (0 whenever s_readDataValid is 0)
//   s_readDataValid       s_readData valid this cycle
// ---------------------------------------------------------------------------
module avl_burst_mem_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_W    = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rest,
  input  logic [31:0]        s_address,
  input  logic [3:0]         s_byteEnable,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [31:0]        s_writeData,
  output logic               s_waitRequest,
  input  logic               s_beginBurstTransfer,
  input  logic [BURST_W-1:0] s_burstCount,
  output logic [31:0]        s_readData,
  output logic               s_readDataValid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;   // next word to read/write
  logic [BURST_W-1:0]    count_reg, count_next;  // beats still to go

  // Command decode
  logic [ADDR_WIDTH-1:0] cmd_word;
  logic [BURST_W-1:0]    cmd_beats;

  assign cmd_word  = s_address[ADDR_WIDTH+1:2];
  assign cmd_beats = (s_burstCount == '0) ? BURST_W'(1) : s_burstCount;

  // Address bits outside the RAM window and the burst-begin strobe carry no
  // information for this slave.
  logic unused_bits;
  assign unused_bits = ^{s_beginBurstTransfer, s_address[31:ADDR_WIDTH+2], s_address[1:0]};

  // RAM port controls
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  busy;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rest) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and RAM port control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = addr_reg;
    busy       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s_read) begin
          // Read wins over a simultaneous write; the write is dropped.
          addr_next  = cmd_word;
          count_next = cmd_beats;
          state_next = RD_BURST;
        end else if (s_write) begin
          // Beat 0 goes straight to the RAM in the accept cycle.
          ram_we     = 1'b1;
          ram_addr   = cmd_word;
          addr_next  = cmd_word + ADDR_WIDTH'(1);
          count_next = cmd_beats - BURST_W'(1);
          if (cmd_beats != BURST_W'(1)) begin
            state_next = WR_BURST;
          end
        end
      end

      RD_BURST: begin
        // One RAM read per cycle; the bus is stalled until the last issue.
        busy       = 1'b1;
        ram_re     = 1'b1;
        addr_next  = addr_reg + ADDR_WIDTH'(1);
        count_next = count_reg - BURST_W'(1);
        if (count_reg == BURST_W'(1)) begin
          state_next = IDLE;
        end
      end

      WR_BURST: begin
        // Master may insert idle cycles; only s_write beats advance.
        if (s_write) begin
          ram_we     = 1'b1;
          addr_next  = addr_reg + ADDR_WIDTH'(1);
          count_next = count_reg - BURST_W'(1);
          if (count_reg == BURST_W'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s_waitRequest = busy | rest;

  // -------------------------------------------------------------------------
  // Single-port word RAM with byte-lane writes and registered read.
  // Contents are not reset; writes are suppressed while rest is high.
  // -------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q_reg;

  always_ff @(posedge clk) begin
    if (ram_we && !rest) begin
      for (int b = 0; b < 4; b++) begin
        if (s_byteEnable[b]) begin
          mem[ram_addr][b*8 +: 8] <= s_writeData[b*8 +: 8];
        end
      end
    end
    ram_q_reg <= mem[ram_addr];
  end

  // -------------------------------------------------------------------------
  // Read return pipeline. The RAM output register is the first stage, so a
  // beat issued in cycle t appears at the output in cycle t+RD_LATENCY.
  // Only the valid bits are reset; data slots are don't-care when invalid.
  // -------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] vld_reg;
  logic [31:0]           rd_pipe_data;

  always_ff @(posedge clk) begin
    if (rest) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= ram_re;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_no_dly
      assign rd_pipe_data = ram_q_reg;
    end else begin : g_dly
      logic [31:0] dly_reg [RD_LATENCY-1];

      always_ff @(posedge clk) begin
        dly_reg[0] <= ram_q_reg;
        for (int i = 1; i < RD_LATENCY - 1; i++) begin
          dly_reg[i] <= dly_reg[i-1];
        end
      end

      assign rd_pipe_data = dly_reg[RD_LATENCY-2];
    end
  endgenerate

  assign s_readDataValid = vld_reg[RD_LATENCY-1];
  // Forcing the data bus to 0 outside valid beats keeps it at 0 after reset.
  assign s_readData      = s_readDataValid ? rd_pipe_data : 32'h0;

endmodule

// File: tb/tb_avl_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_avl_burst_mem_slave
//
// Self-checking bench for avl_burst_mem_slave. A word-array memory model and
// a queue of expected read beats (data + the cycle it must appear in) act as
// the reference; a monitor on the falling edge consumes the queue.
// ---------------------------------------------------------------------------
module tb_avl_burst_mem_slave;

  localparam int ADDR_WIDTH = 10;
  localparam int BURST_W    = 4;
  localparam int RD_LATENCY = 2;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  logic               clk;
  logic               rest;
  logic [31:0]        s_address;
  logic [3:0]         s_byteEnable;
  logic               s_read;
  logic               s_write;
  logic [31:0]        s_writeData;
  logic               s_waitRequest;
  logic               s_beginBurstTransfer;
  logic [BURST_W-1:0] s_burstCount;
  logic [31:0]        s_readData;
  logic               s_readDataValid;

  avl_burst_mem_slave #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_W    (BURST_W),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clk                  (clk),
    .rest                 (rest),
    .s_address            (s_address),
    .s_byteEnable         (s_byteEnable),
    .s_read               (s_read),
    .s_write              (s_write),
    .s_writeData          (s_writeData),
    .s_waitRequest        (s_waitRequest),
    .s_beginBurstTransfer (s_beginBurstTransfer),
    .s_burstCount         (s_burstCount),
    .s_readData           (s_readData),
    .s_readDataValid      (s_readDataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          tag;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [31:0] wr_addr;
    logic [31:0] init;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model_mem[w][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All bench activity happens 1 time unit after the falling edge, so the
  // monitor below always samples before the stimulus for that cycle changes.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every valid beat must match the head of the expected queue in
  // both data and cycle.
  always @(negedge clk) begin
    if (s_readDataValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_beat_unexpected: got data=%h at cycle %0d, required no beat", s_readData, cyc);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        if (s_readData !== b.data || cyc != b.cyc) begin
          failures++;
          $display("FAIL rd_beat tag=%0d: got data=%h cycle=%0d required data=%h cycle=%0d",
                   b.tag, s_readData, cyc, b.data, b.cyc);
        end
      end
    end
  end

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] cnt,
                             input logic [31:0] base, input logic [3:0] be,
                             input bit rnd_data, input bit rnd_ctl);
    int n;
    int w;
    n = (cnt == 0) ? 1 : int'(cnt);
    w = int'(addr[ADDR_WIDTH+1:2]);
    $display("WR addr=%h beats=%0d", addr, n);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && rnd_ctl) begin
        repeat ($urandom_range(0, 2)) begin
          // Idle cycle inside the burst; a stray s_read must be ignored.
          s_write     = 1'b0;
          s_read      = 1'($urandom_range(0, 1));
          s_writeData = $urandom;
          step();
        end
      end
      s_read               = 1'b0;
      s_write              = 1'b1;
      s_address            = addr;
      s_burstCount         = cnt;
      s_beginBurstTransfer = (i == 0);
      s_writeData          = rnd_data ? $urandom : base + 32'(i);
      s_byteEnable         = rnd_ctl ? 4'($urandom) : be;
      check32(i == 0 ? "wr_accept_wait" : "wr_beat_wait", {31'b0, s_waitRequest}, 32'd0);
      model_write((w + i) % DEPTH, s_writeData, s_byteEnable);
      step();
    end
    s_write              = 1'b0;
    s_read               = 1'b0;
    s_beginBurstTransfer = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] cnt,
                            input bit ovr, input logic [31:0] ovr_data,
                            input bit both, input int tag);
    int n;
    int w;
    beat_t b;
    n = (cnt == 0) ? 1 : int'(cnt);
    w = int'(addr[ADDR_WIDTH+1:2]);
    $display("RD addr=%h beats=%0d tag=%0d", addr, n, tag);
    s_read               = 1'b1;
    s_write              = both;  // dropped by the slave when s_read is set
    s_writeData          = $urandom;
    s_byteEnable         = 4'hF;
    s_address            = addr;
    s_burstCount         = cnt;
    s_beginBurstTransfer = 1'b1;
    check32("rd_accept_wait", {31'b0, s_waitRequest}, 32'd0);
    for (int i = 0; i < n; i++) begin
      b.data = ovr ? ovr_data : model_mem[(w + i) % DEPTH];
      b.cyc  = cyc + 1 + RD_LATENCY + i;
      b.tag  = tag;
      exp_q.push_back(b);
    end
    step();
    s_beginBurstTransfer = 1'b0;
    for (int i = 0; i < n; i++) begin
      // Stalled: commands presented now must be ignored.
      s_read      = 1'($urandom_range(0, 1));
      s_write     = 1'($urandom_range(0, 1));
      s_writeData = $urandom;
      check32("rd_busy_wait", {31'b0, s_waitRequest}, 32'd1);
      step();
    end
    s_read  = 1'b0;
    s_write = 1'b0;
    check32("rd_done_wait", {31'b0, s_waitRequest}, 32'd0);
  endtask

  initial begin
    int k;
    beat_t b;

    vecs[0] = '{32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'h5, 32'h0000_0000, 32'h0000_0020, 32'hFF00_FF00};
    vecs[2] = '{32'h0000_0024, 32'h0000_0000, 4'hA, 32'h1234_5678, 32'h0000_0024, 32'h1200_5600};
    vecs[3] = '{32'h0000_0028, 32'hAAAA_AAAA, 4'h0, 32'h5555_5555, 32'h0000_0028, 32'hAAAA_AAAA};
    vecs[4] = '{32'h0000_002C, 32'h1122_3344, 4'h8, 32'hFF00_0000, 32'h0000_002C, 32'hFF22_3344};
    vecs[5] = '{32'hF000_1000, 32'h0BAD_0BAD, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D};

    rest                 = 1'b1;
    s_address            = '0;
    s_byteEnable         = '0;
    s_read               = 1'b0;
    s_write              = 1'b0;
    s_writeData          = '0;
    s_beginBurstTransfer = 1'b0;
    s_burstCount         = '0;

    // Reset state
    step();
    step();
    check32("rst_valid", {31'b0, s_readDataValid}, 32'd0);
    check32("rst_data", s_readData, 32'd0);
    check32("rst_wait", {31'b0, s_waitRequest}, 32'd1);
    rest = 1'b0;
    step();
    check32("post_rst_wait", {31'b0, s_waitRequest}, 32'd0);

    // Fill the whole RAM so every later read has a defined expectation.
    for (int a = 0; a < DEPTH; a += 8) begin
      write_burst(32'(a * 4), 4'd8, 32'h0, 4'hF, 1'b1, 1'b0);
    end

    // Table: init word, partial write, read back against a fixed constant.
    for (int i = 0; i < 6; i++) begin
      write_burst(vecs[i].wr_addr, 4'd1, vecs[i].init, 4'hF, 1'b0, 1'b0);
      write_burst(vecs[i].wr_addr, 4'd1, vecs[i].wdata, vecs[i].be, 1'b0, 1'b0);
      read_burst(vecs[i].rd_addr, 4'd1, 1'b1, vecs[i].exp, 1'b0, 100 + i);
    end

    // 8-beat burst write and burst read
    write_burst(32'h40, 4'd8, 32'h0, 4'hF, 1'b0, 1'b0);
    read_burst(32'h40, 4'd8, 1'b0, 32'h0, 1'b0, 2);

    // Wrap from the last word
    write_burst(32'hFFC, 4'd4, 32'hA000_0000, 4'hF, 1'b0, 1'b0);
    read_burst(32'hFFC, 4'd4, 1'b0, 32'h0, 1'b0, 4);

    // Back-to-back reads, counts 2 and 3
    read_burst(32'h40, 4'd2, 1'b0, 32'h0, 1'b0, 5);
    read_burst(32'h50, 4'd3, 1'b0, 32'h0, 1'b0, 5);

    // Count 0 acts as 1, maximum burst of 15 both ways
    read_burst(32'h44, 4'd0, 1'b0, 32'h0, 1'b0, 7);
    write_burst(32'h200, 4'd15, 32'h5A00_0000, 4'hF, 1'b0, 1'b0);
    read_burst(32'h200, 4'd15, 1'b0, 32'h0, 1'b0, 8);

    // Reset in the middle of an 8-beat read: only beats before reset arrive.
    repeat (RD_LATENCY + 2) step();
    $display("RD addr=%h beats=8 tag=6 (aborted by reset)", 32'h40);
    s_read       = 1'b1;
    s_address    = 32'h40;
    s_burstCount = 4'd8;
    check32("rst_mid_accept_wait", {31'b0, s_waitRequest}, 32'd0);
    k = cyc;
    for (int i = 0; i < 2; i++) begin
      b.data = model_mem[16 + i];
      b.cyc  = k + 1 + RD_LATENCY + i;
      b.tag  = 6;
      exp_q.push_back(b);
    end
    step();
    s_read = 1'b0;
    while (cyc < k + 2 + RD_LATENCY) step();
    rest = 1'b1;
    exp_q.delete();
    step();
    check32("rst_mid_valid", {31'b0, s_readDataValid}, 32'd0);
    check32("rst_mid_wait", {31'b0, s_waitRequest}, 32'd1);
    rest = 1'b0;
    step();
    check32("rst_mid_idle_wait", {31'b0, s_waitRequest}, 32'd0);
    check32("rst_mid_idle_valid", {31'b0, s_readDataValid}, 32'd0);
    read_burst(32'h40, 4'd4, 1'b0, 32'h0, 1'b0, 6);

    // Randomized traffic against the model
    for (int t = 0; t < 80; t++) begin
      logic [31:0] ra;
      logic [3:0]  rc;
      ra = $urandom;
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 5) begin
        write_burst(ra, rc, 32'h0, 4'hF, 1'b1, 1'b1);
      end else begin
        read_burst(ra, rc, 1'b0, 32'h0, ($urandom_range(0, 4) == 0), 200 + t);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Drain outstanding beats, bounded
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check32("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
